// File: rtl/cordic_iter_engine_if.sv
// ----------------------------------------------------------------------------
// cordic_iter_engine_if
//   Handshake bundle between an operand producer/result consumer and the
//   iterative CORDIC engine.
//
//   Producer side : mode, in_valid, x_in, y_in, z_in -> engine; in_ready back.
//   Consumer side : out_valid, x_out, y_out, z_out, busy -> consumer;
//                   out_ready back.
//
//   master : the producer/consumer (testbench or surrounding logic)
//   slave  : the engine
// ----------------------------------------------------------------------------
interface cordic_iter_engine_if #(
  parameter int WIDTH = 32
);
  logic                    mode;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] x_in;
  logic signed [WIDTH-1:0] y_in;
  logic signed [WIDTH-1:0] z_in;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] x_out;
  logic signed [WIDTH-1:0] y_out;
  logic signed [WIDTH-1:0] z_out;
  logic                    busy;

  modport master (
    output mode, in_valid, x_in, y_in, z_in, out_ready,
    input  in_ready, out_valid, x_out, y_out, z_out, busy
  );

  modport slave (
    input  mode, in_valid, x_in, y_in, z_in, out_ready,
    output in_ready, out_valid, x_out, y_out, z_out, busy
  );
endinterface

// File: rtl/cordic_iter_engine.sv
// ----------------------------------------------------------------------------
// cordic_iter_engine
//   Iterative CORDIC: one micro-rotation per clock through a single
//   shift-add stage. Rotation mode drives z toward 0, vectoring mode drives
//   y toward 0. An operation takes ITER clocks of RUN, then the result is
//   presented in DONE until the consumer takes it.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous reset, active-high
//   bus (slave)    mode/in_valid/in_ready/x_in/y_in/z_in   operand handshake
//                  out_valid/out_ready/x_out/y_out/z_out   result handshake
//                  busy                                    high in RUN or DONE
//
// Parameters
//   WIDTH  datapath width, 8..32; angle scale 2^(WIDTH-1) = pi
//   ITER   micro-rotations per operation, 1..min(WIDTH-1,24)
// ----------------------------------------------------------------------------
module cordic_iter_engine #(
  parameter int WIDTH = 32,
  parameter int ITER  = 16
) (
  input logic           clk,
  input logic           rst,
  cordic_iter_engine_if.slave bus
);

  localparam int               CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    mode_q, mode_d;
  logic signed [WIDTH-1:0] x_q, x_d;
  logic signed [WIDTH-1:0] y_q, y_d;
  logic signed [WIDTH-1:0] z_q, z_d;
  logic signed [WIDTH-1:0] xo_q, xo_d;
  logic signed [WIDTH-1:0] yo_q, yo_d;
  logic signed [WIDTH-1:0] zo_q, zo_d;

  logic                    d_pos;
  logic signed [31:0]      atan32;
  logic signed [WIDTH-1:0] atan_w;
  logic signed [WIDTH-1:0] x_sh, y_sh;
  logic signed [WIDTH-1:0] x_step, y_step, z_step;

  // round(atan(2^-i)/pi * 2^31); pi maps to 2^31 at full 32-bit width.
  function automatic logic [31:0] atan_rom(input logic [4:0] idx);
    case (idx)
      5'd0:    atan_rom = 32'h2000_0000;
      5'd1:    atan_rom = 32'h12E4_051E;
      5'd2:    atan_rom = 32'h09FB_385B;
      5'd3:    atan_rom = 32'h0511_11D4;
      5'd4:    atan_rom = 32'h028B_0D43;
      5'd5:    atan_rom = 32'h0145_D7E1;
      5'd6:    atan_rom = 32'h00A2_F61E;
      5'd7:    atan_rom = 32'h0051_7C55;
      5'd8:    atan_rom = 32'h0028_BE53;
      5'd9:    atan_rom = 32'h0014_5F2F;
      5'd10:   atan_rom = 32'h000A_2F98;
      5'd11:   atan_rom = 32'h0005_17CC;
      5'd12:   atan_rom = 32'h0002_8BE6;
      5'd13:   atan_rom = 32'h0001_45F3;
      5'd14:   atan_rom = 32'h0000_A2FA;
      5'd15:   atan_rom = 32'h0000_517D;
      5'd16:   atan_rom = 32'h0000_28BE;
      5'd17:   atan_rom = 32'h0000_145F;
      5'd18:   atan_rom = 32'h0000_0A30;
      5'd19:   atan_rom = 32'h0000_0518;
      5'd20:   atan_rom = 32'h0000_028C;
      5'd21:   atan_rom = 32'h0000_0146;
      5'd22:   atan_rom = 32'h0000_00A3;
      5'd23:   atan_rom = 32'h0000_0051;
      default: atan_rom = 32'h0000_0000;
    endcase
  endfunction

  // Narrower datapaths keep the top WIDTH bits of the 32-bit angle table.
  assign atan32 = $signed(atan_rom(5'(cnt_q)));
  assign atan_w = WIDTH'(atan32 >>> (32 - WIDTH));

  // Direction: rotation steps toward z=0 (d=+1 only for z>0), vectoring
  // toward y=0 (d=+1 only for y<0); a zero residual always picks d=-1.
  assign d_pos = mode_q ? y_q[WIDTH-1] : (~z_q[WIDTH-1] & (|z_q));

  assign x_sh   = x_q >>> cnt_q;
  assign y_sh   = y_q >>> cnt_q;
  assign x_step = d_pos ? (x_q - y_sh)   : (x_q + y_sh);
  assign y_step = d_pos ? (y_q + x_sh)   : (y_q - x_sh);
  assign z_step = d_pos ? (z_q - atan_w) : (z_q + atan_w);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    zo_d    = zo_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          mode_d  = bus.mode;
          x_d     = bus.x_in;
          y_d     = bus.y_in;
          z_d     = bus.z_in;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        x_d = x_step;
        y_d = y_step;
        z_d = z_step;
        if (cnt_q == LAST) begin
          xo_d    = x_step;
          yo_d    = y_step;
          zo_d    = z_step;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and visible result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
      zo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      zo_q    <= zo_d;
    end
  end

  // Working datapath registers; always reloaded on accept, so no reset.
  always_ff @(posedge clk) begin
    mode_q <= mode_d;
    x_q    <= x_d;
    y_q    <= y_d;
    z_q    <= z_d;
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.x_out     = xo_q;
  assign bus.y_out     = yo_q;
  assign bus.z_out     = zo_q;

endmodule
